// File: rtl/seg7_decode_capture.sv
// Decodes six active-low 7-segment buses back into a 24-bit value and presents each new stable
// display content once on a valid/ready output. Optional macro: SEG7_DECODE_BLANK_EN.
module seg7_decode_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  hex0,
  input  logic [6:0]  hex1,
  input  logic [6:0]  hex2,
  input  logic [6:0]  hex3,
  input  logic [6:0]  hex4,
  input  logic [6:0]  hex5,
  output logic [23:0] value,
  output logic [5:0]  invalid,
  output logic        valid,
  input  logic        ready
);

  localparam logic [7:0] StableMax  = 8'(STABLE_CYCLES);
  localparam logic [7:0] StableLast = 8'(STABLE_CYCLES - 1);

  typedef enum logic {StEmpty, StFull} state_e;

  // Returns {unrecognised, nibble}.
  function automatic logic [4:0] decode_digit(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h40:   r = 5'h00;
      7'h79:   r = 5'h01;
      7'h24:   r = 5'h02;
      7'h30:   r = 5'h03;
      7'h19:   r = 5'h04;
      7'h12:   r = 5'h05;
      7'h02:   r = 5'h06;
      7'h78:   r = 5'h07;
      7'h00:   r = 5'h08;
      7'h10:   r = 5'h09;
      7'h08:   r = 5'h0A;
      7'h03:   r = 5'h0B;
      7'h46:   r = 5'h0C;
      7'h21:   r = 5'h0D;
      7'h06:   r = 5'h0E;
      7'h0E:   r = 5'h0F;
`ifdef SEG7_DECODE_BLANK_EN
      7'h7F:   r = 5'h00;
`else
      7'h7F:   r = 5'h10;
`endif
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  logic [41:0] raw;
  logic [41:0] sync1_q, snap_q, last_q, last_d;
  logic        have_last_q, have_last_d;
  logic [1:0]  prime_q;
  logic [7:0]  cnt_q, cnt_d;
  logic        snap_change, candidate, cand_new;
  logic [23:0] cand_value;
  logic [5:0]  cand_invalid;

  state_e      state_q, state_d;
  logic [23:0] value_q, value_d, pend_value_q, pend_value_d;
  logic [5:0]  invalid_q, invalid_d, pend_invalid_q, pend_invalid_d;
  logic        pend_q, pend_d;

  assign raw = {hex5, hex4, hex3, hex2, hex1, hex0};

  // prime_q keeps the cleared synchroniser contents from ever being treated as a candidate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      snap_q  <= '0;
      prime_q <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      snap_q  <= sync1_q;
      prime_q <= {prime_q[0], 1'b1};
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    snap_change = (sync1_q != snap_q);
    cnt_d       = cnt_q;
    if (snap_change) begin
      cnt_d = '0;
    end else if (cnt_q != StableMax) begin
      cnt_d = cnt_q + 8'd1;
    end
    // Fires on the edge the counter reaches the threshold, so only once per stable content.
    candidate = prime_q[1] && !snap_change && (cnt_q == StableLast);
    cand_new  = candidate && (!have_last_q || (snap_q != last_q));
  end

  always_comb begin
    cand_value   = '0;
    cand_invalid = '0;
    for (int i = 0; i < 6; i++) begin
      logic [4:0] d;
      d                     = decode_digit(snap_q[7*i +: 7]);
      cand_value[4*i +: 4]  = d[3:0];
      cand_invalid[i]       = d[4];
    end
  end

  always_comb begin
    state_d        = state_q;
    value_d        = value_q;
    invalid_d      = invalid_q;
    pend_d         = pend_q;
    pend_value_d   = pend_value_q;
    pend_invalid_d = pend_invalid_q;
    last_d         = last_q;
    have_last_d    = have_last_q;

    unique case (state_q)
      StEmpty: begin
        if (cand_new) begin
          value_d     = cand_value;
          invalid_d   = cand_invalid;
          last_d      = snap_q;
          have_last_d = 1'b1;
          state_d     = StFull;
        end
      end
      StFull: begin
        if (cand_new) begin
          last_d      = snap_q;
          have_last_d = 1'b1;
          if (ready) begin
            // Candidate is newer than anything pending, so it goes straight to the output.
            value_d   = cand_value;
            invalid_d = cand_invalid;
            pend_d    = 1'b0;
          end else begin
            pend_d         = 1'b1;
            pend_value_d   = cand_value;
            pend_invalid_d = cand_invalid;
          end
        end else if (ready) begin
          if (pend_q) begin
            value_d   = pend_value_q;
            invalid_d = pend_invalid_q;
            pend_d    = 1'b0;
          end else begin
            state_d = StEmpty;
          end
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StEmpty;
      value_q        <= '0;
      invalid_q      <= '0;
      pend_q         <= 1'b0;
      pend_value_q   <= '0;
      pend_invalid_q <= '0;
      last_q         <= '0;
      have_last_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      value_q        <= value_d;
      invalid_q      <= invalid_d;
      pend_q         <= pend_d;
      pend_value_q   <= pend_value_d;
      pend_invalid_q <= pend_invalid_d;
      last_q         <= last_d;
      have_last_q    <= have_last_d;
    end
  end

  assign value   = value_q;
  assign invalid = invalid_q;
  assign valid   = (state_q == StFull);

endmodule

// File: tb/tb_seg7_decode_capture.sv
// Scoreboard bench for seg7_decode_capture: stimulus pushes expected captures, a negedge monitor
// pops and compares on every valid && ready.
module tb_seg7_decode_capture;

  logic        clk;
  logic        rst;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic [23:0] value;
  logic [5:0]  invalid;
  logic        valid;
  logic        ready;

  int          n_checks;
  int          n_fail;
  logic [29:0] exp_q[$];

  seg7_decode_capture #(.STABLE_CYCLES(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .hex0    (hex0),
    .hex1    (hex1),
    .hex2    (hex2),
    .hex3    (hex3),
    .hex4    (hex4),
    .hex5    (hex5),
    .value   (value),
    .invalid (invalid),
    .valid   (valid),
    .ready   (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  task automatic set_hex(input logic [23:0] v);
    hex0 = enc(v[3:0]);
    hex1 = enc(v[7:4]);
    hex2 = enc(v[11:8]);
    hex3 = enc(v[15:12]);
    hex4 = enc(v[19:16]);
    hex5 = enc(v[23:20]);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every presented capture accepted by the consumer must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst && valid && ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_capture: got value=%h invalid=%b, expected none", value,
                 invalid);
      end else begin
        logic [29:0] e;
        e = exp_q.pop_front();
        if ({value, invalid} !== e) begin
          n_fail++;
          $display("FAIL capture: got value=%h invalid=%b, expected value=%h invalid=%b",
                   value, invalid, e[29:6], e[5:0]);
        end
      end
    end
  end

  logic [5:0] blank_inv;

  initial begin
    n_checks = 0;
    n_fail   = 0;
`ifdef SEG7_DECODE_BLANK_EN
    blank_inv = 6'b000000;
`else
    blank_inv = 6'b000001;
`endif
    rst   = 1'b1;
    ready = 1'b1;
    set_hex(24'h12AB9F);
    exp_q.push_back({24'h12AB9F, 6'b0});
    tick(2);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_value", 32'(value), 32'd0);
    check("reset_invalid", 32'(invalid), 32'd0);
    rst = 1'b0;

    // Capture latency: valid rises after the sixth edge following the input change.
    tick(5);
    check("latency_not_yet", 32'(valid), 32'd0);
    tick(1);
    check("latency_valid", 32'(valid), 32'd1);
    check("latency_value", 32'(value), 32'h12AB9F);
    tick(20);

    // Short glitch on digit 2, then back to already-captured content: nothing new.
    hex2 = enc(4'h2);
    tick(3);
    hex2 = enc(4'hB);
    tick(20);
    check("glitch_value", 32'(value), 32'h12AB9F);

    hex0 = 7'h7F;
    exp_q.push_back({24'h12AB90, blank_inv});
    tick(12);

    for (int d = 0; d < 16; d++) begin
      logic [3:0] n;
      n = 4'(d);
      set_hex({6{n}});
      exp_q.push_back({{6{n}}, 6'b0});
      tick(8);
    end
    check("sweep_drained", 32'(exp_q.size()), 32'd0);

    // Back-pressure: first capture held, second waits in the pending slot.
    ready = 1'b0;
    set_hex(24'h111111);
    exp_q.push_back({24'h111111, 6'b0});
    tick(10);
    set_hex(24'h222222);
    exp_q.push_back({24'h222222, 6'b0});
    tick(10);
    check("bp_valid", 32'(valid), 32'd1);
    check("bp_head", 32'(value), 32'h111111);
    ready = 1'b1;
    tick(15);
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // Reset with a pending capture: outputs clear at once; stable content recaptured.
    ready = 1'b0;
    set_hex(24'h333333);
    exp_q.push_back({24'h333333, 6'b0});
    tick(10);
    set_hex(24'h444444);
    exp_q.push_back({24'h444444, 6'b0});
    tick(10);
    check("pre_reset_valid", 32'(valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_valid", 32'(valid), 32'd0);
    check("async_reset_value", 32'(value), 32'd0);
    check("async_reset_invalid", 32'(invalid), 32'd0);
    exp_q.delete();
    tick(2);
    rst = 1'b0;
    exp_q.push_back({24'h444444, 6'b0});
    tick(10);
    check("recapture_valid", 32'(valid), 32'd1);
    ready = 1'b1;

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick(1);
    tick(10);
    check("final_drained", 32'(exp_q.size()), 32'd0);
    check("final_idle", 32'(valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
